// File: rtl/ps2_bitrec.sv
// ps2_bitrec: PS/2 keyboard receiver; synchronises and de-glitches the pins, deserialises 11-bit frames, strobes out good bytes
// Ports: clk system clock; resetN sync active-low reset; kbd_clk/kbd_dat raw PS/2 pins (idle high);
//        dout last good byte; dout_new 1-cycle update strobe; parity_err / frame_err 1-cycle error strobes
module ps2_bitrec #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       kbd_clk,
    input  logic       kbd_dat,
    output logic [7:0] dout,
    output logic       dout_new,
    output logic       parity_err,
    output logic       frame_err
);
    localparam int FW = $clog2(FILT_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] clk_sync_q, dat_sync_q;
    logic                   filt_q;
    logic [FW-1:0]          filt_cnt_q;
    logic                   clk_s, dat_s, flip, fall_det;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             sh_q, sh_d, dout_q, dout_d;
    logic                   par_q, par_d;
    logic [TW-1:0]          tmo_q, tmo_d;
    logic                   dout_new_q, dout_new_d, parity_err_q, parity_err_d, frame_err_q, frame_err_d;
    assign clk_s    = clk_sync_q[SYNC_STAGES-1];
    assign dat_s    = dat_sync_q[SYNC_STAGES-1];
    // the FILT_LEN-th consecutive differing sample flips the filtered clock
    assign flip     = (clk_s != filt_q) && (filt_cnt_q == FW'(FILT_LEN - 1));
    assign fall_det = flip && filt_q;
    always_ff @(posedge clk) begin
        if (!resetN) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            filt_q     <= 1'b1;
            filt_cnt_q <= '0;
        end else begin
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], kbd_clk};
            dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], kbd_dat};
            filt_q     <= flip ? ~filt_q : filt_q;
            filt_cnt_q <= (flip || clk_s == filt_q) ? '0 : filt_cnt_q + 1'b1;
        end
    end
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        sh_d         = sh_q;
        par_d        = par_q;
        dout_d       = dout_q;
        dout_new_d   = 1'b0;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;
        tmo_d        = (state_q == IDLE || fall_det) ? '0 : tmo_q + 1'b1;
        // a falling edge takes priority over a simultaneous timeout
        if (fall_det) begin
            case (state_q)
                IDLE: begin
                    state_d   = dat_s ? IDLE : DATA;
                    bit_cnt_d = '0;
                end
                DATA: begin
                    sh_d      = {dat_s, sh_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    state_d   = (bit_cnt_q == 3'd7) ? PARITY : DATA;
                end
                PARITY: begin
                    par_d   = dat_s;
                    state_d = STOP;
                end
                default: begin
                    state_d      = IDLE;
                    frame_err_d  = !dat_s;
                    dout_new_d   = dat_s && (^{sh_q, par_q});
                    parity_err_d = dat_s && !(^{sh_q, par_q});
                    dout_d       = dout_new_d ? sh_q : dout_q;
                end
            endcase
        end else if (state_q != IDLE && tmo_q == TW'(TIMEOUT_CYC)) begin
            state_d     = IDLE;
            frame_err_d = 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            sh_q         <= '0;
            par_q        <= 1'b0;
            tmo_q        <= '0;
            dout_q       <= '0;
            dout_new_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            sh_q         <= sh_d;
            par_q        <= par_d;
            tmo_q        <= tmo_d;
            dout_q       <= dout_d;
            dout_new_q   <= dout_new_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end
    assign dout       = dout_q;
    assign dout_new   = dout_new_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
endmodule
